rom_sample_player: RTL
======================

ROM_SAMPLE_PLAYER -- requirements
Module: rom_sample_player

Interface
REQ-001 SHALL have parameter W, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter L, default 25000, meaning number of samples in the ROM; address width AW = $clog2(L).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, meaning begin playback from address 0.
REQ-006 SHALL have port stop, input, 1, meaning abort playback.
REQ-007 SHALL have port loop, input, 1, meaning restart at address 0 after the last sample instead of finishing.
REQ-008 SHALL have port rom_addr, output, AW, meaning read address to the synchronous sample ROM, which has 1-cycle read latency.
REQ-009 SHALL have port rom_rd_data, input, W, meaning ROM read data, valid one cycle after rom_addr.
REQ-010 SHALL have port sample_data, output, W, meaning the sample offered downstream to the I2S serializer.
REQ-011 SHALL have port sample_valid, output, 1, meaning sample_data is valid.
REQ-012 SHALL have port sample_ready, input, 1, meaning the downstream stage accepts sample_data.
REQ-013 SHALL have port busy, output, 1, meaning high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1, meaning a one-cycle pulse after the final sample is accepted in non-loop mode.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT and HOLD.
REQ-016 IDLE: start=1 SHALL set rom_addr=0 and go to READ; start SHALL be ignored in all other states.
REQ-017 READ SHALL present rom_addr unchanged and go to WAIT.
REQ-018 WAIT SHALL register rom_rd_data into sample_data, set sample_valid=1 and go to HOLD.
REQ-019 Latency: if start is sampled at edge k, sample_valid SHALL be high after edge k+2.
REQ-020 HOLD: sample_data and sample_valid SHALL remain stable while sample_ready=0.
REQ-021 HOLD with sample_ready=1, not last address: a transfer SHALL occur; sample_valid SHALL clear, rom_addr SHALL increment by 1 and the FSM SHALL go to READ.
REQ-022 Throughput: at most one sample every 3 cycles, which suffices for audio-rate consumption.
REQ-023 Transfer at rom_addr=L-1 with loop=1 (loop sampled at the transfer edge) SHALL set rom_addr=0 and go to READ, with no done pulse.
REQ-024 Transfer at rom_addr=L-1 with loop=0 SHALL go to IDLE and assert done for exactly the next cycle.
REQ-025 stop=1 in any non-IDLE state SHALL force IDLE at the next edge, clear sample_valid and produce no done pulse; a pending unaccepted sample SHALL be discarded.
REQ-026 Simultaneous stop and start in IDLE: stop SHALL win and the FSM SHALL stay in IDLE.
REQ-027 Simultaneous stop and transfer in HOLD: the transfer SHALL count as accepted, stop SHALL win (go to IDLE) and done SHALL NOT pulse.
REQ-028 rom_addr SHALL never exceed L-1, and its increment SHALL be done at AW bits with no wrap beyond L-1.
REQ-029 In IDLE, rom_addr SHALL hold its last value and sample_data SHALL hold its last value.

Reset
REQ-030 rst SHALL asynchronously force state=IDLE, rom_addr=0, sample_data=0, sample_valid=0, done=0 and busy=0.
REQ-031 Reset asserted mid-playback SHALL discard all progress; after rst deasserts, playback SHALL resume only on a new start.

Structure
REQ-032 The state enum typedef SHALL reside in shared package i2s_pkg, together with the default W and L constants.
REQ-033 The block SHALL be a single module with no sub-modules; the parent SHALL instantiate the ROM and connect rom_addr and rom_rd_data.

Verification
REQ-034 With L=8 and ROM[i]=16'h1000+i, sample_ready held at 1, start pulsed at edge k: sample_valid SHALL rise after edge k+2, data SHALL be 1000..1007 at 3-cycle spacing, and done SHALL pulse once after 1007.
REQ-035 Backpressure: with sample_ready=0 for 10 cycles at sample 3, sample_data SHALL hold 16'h1003 and sample_valid SHALL stay 1; no sample SHALL be skipped or duplicated.
REQ-036 loop=1: the output SHALL be 1007 followed by 1000 with no done pulse, continuing for 3 full passes.
REQ-037 stop asserted in WAIT at address 5: the FSM SHALL be in IDLE next cycle with sample_valid=0 and no done; a new start SHALL produce 1000 first.
REQ-038 rst asserted asynchronously mid-HOLD: all outputs SHALL be zero immediately, with no waiting for a clock edge.
REQ-039 start and stop high together in IDLE: busy SHALL stay 0; a start pulse during HOLD SHALL have no effect on the sequence.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S audio path: sample-player FSM states and default sizing.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } player_state_t;

  localparam int unsigned W_DEFAULT = 16;
  localparam int unsigned L_DEFAULT = 25000;

endpackage

// File: rtl/rom_sample_player.sv
// Streams samples from a 1-cycle-latency synchronous ROM to the I2S serializer
// with a valid/ready handshake; optional looping, abort via stop.
module rom_sample_player
  import i2s_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned L  = L_DEFAULT,
  localparam int unsigned AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [AW-1:0] rom_addr,
  input  logic [W-1:0]  rom_rd_data,
  output logic [W-1:0]  sample_data,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(L - 1);

  player_state_t state, state_nxt;

  logic addr_clr, addr_inc, data_load, valid_set, valid_clr, done_nxt;
  logic last;

  assign last = (rom_addr == LAST_ADDR);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    data_load = 1'b0;
    valid_set = 1'b0;
    valid_clr = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = READ;
          addr_clr  = 1'b1;
        end
      end
      READ: state_nxt = stop ? IDLE : WAIT;
      WAIT: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
          data_load = 1'b1;
          valid_set = 1'b1;
        end
      end
      HOLD: begin
        // stop takes priority; a coincident transfer is still consumed, but no done.
        if (stop) begin
          state_nxt = IDLE;
          valid_clr = 1'b1;
        end else if (sample_ready) begin
          valid_clr = 1'b1;
          if (!last) begin
            state_nxt = READ;
            addr_inc  = 1'b1;
          end else if (loop) begin
            state_nxt = READ;
            addr_clr  = 1'b1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr     <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= done_nxt;
      if (addr_clr)      rom_addr <= '0;
      else if (addr_inc) rom_addr <= rom_addr + AW'(1);
      if (data_load) sample_data <= rom_rd_data;
      if (valid_set)      sample_valid <= 1'b1;
      else if (valid_clr) sample_valid <= 1'b0;
    end
  end

endmodule
